math_dismiss_ctrl: RTL

- Sequencer for the math-question alarm dismissal path.
- While the alarm is ringing it generates addition questions and drives question_a/question_b to the hex display.
- It collects a two-digit answer from switches and key presses, and drives question_c with the entry in progress.
- After NUM_QUESTIONS consecutive correct answers it pulses alarm_off to the alarm state module. A wrong answer imposes a lockout and a fresh question.

---
 rtl/math_dismiss_ctrl.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/math_dismiss_ctrl.sv
// Math-question alarm dismissal sequencer: generates addition questions, collects a
// two-digit BCD answer from keys and pulses alarm_off after enough consecutive correct answers.
module math_dismiss_ctrl #(
  parameter int unsigned NUM_QUESTIONS  = 3,
  parameter int unsigned PENALTY_CYCLES = 50_000_000,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       alarm_on,
  input  logic [3:0] digit_in,
  input  logic       digit_key,
  input  logic       submit_key,
  output logic [6:0] question_a,
  output logic [6:0] question_b,
  output logic [6:0] question_c,
  output logic       alarm_off,
  output logic       wrong,
  output logic [2:0] remaining,
  output logic       busy
);

  localparam int unsigned     CNT_W     = (PENALTY_CYCLES > 1) ? $clog2(PENALTY_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PENALTY_CYCLES - 1);
  localparam logic [2:0]      REM_INIT  = 3'(NUM_QUESTIONS);
  localparam logic [15:0]     LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    S_IDLE, S_GEN, S_ENTRY, S_CHECK, S_PENALTY, S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [2:0]       dsync_q, dsync_d;
  logic [2:0]       ssync_q, ssync_d;
  logic [3:0]       tens_q, tens_d;
  logic [3:0]       ones_q, ones_d;
  logic [6:0]       qa_q, qa_d;
  logic [6:0]       qb_q, qb_d;
  logic [6:0]       qc_q, qc_d;
  logic             off_q, off_d;
  logic             wrong_q, wrong_d;
  logic [2:0]       rem_q, rem_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;

  logic       digit_ev, submit_ev, match;
  logic [5:0] r_a, r_b;
  logic [6:0] entry_val;

  // Bits [1:0] of each sync chain are the synchroniser, bit [2] is the edge-detect history.
  assign digit_ev  = dsync_q[1] & ~dsync_q[2];
  assign submit_ev = ssync_q[1] & ~ssync_q[2];
  assign match     = (qc_q == 7'(qa_q + qb_q));
  assign r_a       = lfsr_q[5:0];
  assign r_b       = lfsr_q[13:8];
  assign entry_val = 7'(ones_q) * 7'd10 + 7'(digit_in);

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Datapath and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lfsr_q  <= LFSR_SEED;
      dsync_q <= '0;
      ssync_q <= '0;
      tens_q  <= '0;
      ones_q  <= '0;
      qa_q    <= '0;
      qb_q    <= '0;
      qc_q    <= '0;
      off_q   <= 1'b0;
      wrong_q <= 1'b0;
      rem_q   <= REM_INIT;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      lfsr_q  <= lfsr_d;
      dsync_q <= dsync_d;
      ssync_q <= ssync_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      qa_q    <= qa_d;
      qb_q    <= qb_d;
      qc_q    <= qc_d;
      off_q   <= off_d;
      wrong_q <= wrong_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  // Next-state logic; dropping alarm_on overrides every other transition
  always_comb begin
    state_d = state_q;
    if (!alarm_on) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:    state_d = S_GEN;
        S_GEN:     state_d = S_ENTRY;
        S_ENTRY:   if (pend_q || (submit_ev && !digit_ev)) state_d = S_CHECK;
        S_CHECK: begin
          if (!match)             state_d = S_PENALTY;
          else if (rem_q > 3'd1)  state_d = S_GEN;
          else                    state_d = S_DONE;
        end
        S_PENALTY: if (cnt_q == '0) state_d = S_GEN;
        S_DONE:    state_d = S_DONE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // Output and datapath next values
  always_comb begin
    lfsr_d  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    dsync_d = {dsync_q[1:0], digit_key};
    ssync_d = {ssync_q[1:0], submit_key};
    tens_d  = tens_q;
    ones_d  = ones_q;
    qa_d    = qa_q;
    qb_d    = qb_q;
    qc_d    = qc_q;
    off_d   = 1'b0;
    wrong_d = wrong_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    pend_d  = 1'b0;
    busy_d  = (state_d != S_IDLE);

    if (!alarm_on || state_q == S_IDLE) begin
      tens_d  = '0;
      ones_d  = '0;
      qa_d    = '0;
      qb_d    = '0;
      qc_d    = '0;
      wrong_d = 1'b0;
      rem_d   = REM_INIT;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_GEN: begin
          qa_d   = (r_a < 6'd50) ? 7'(r_a) : 7'(r_a - 6'd50);
          qb_d   = (r_b < 6'd50) ? 7'(r_b) : 7'(r_b - 6'd50);
          qc_d   = '0;
          tens_d = '0;
          ones_d = '0;
        end
        S_ENTRY: begin
          if (digit_ev && !pend_q && digit_in <= 4'd9) begin
            tens_d = ones_q;
            ones_d = digit_in;
            qc_d   = entry_val;
          end
          // A submit coinciding with a digit waits one cycle so CHECK sees the new entry.
          pend_d = digit_ev && submit_ev && !pend_q;
        end
        S_CHECK: begin
          if (!match) begin
            rem_d   = REM_INIT;
            wrong_d = 1'b1;
            cnt_d   = CNT_LOAD;
          end else if (rem_q > 3'd1) begin
            rem_d = rem_q - 3'd1;
          end else begin
            rem_d = '0;
            off_d = 1'b1;
          end
        end
        S_PENALTY: begin
          if (cnt_q == '0) wrong_d = 1'b0;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign question_a = qa_q;
  assign question_b = qb_q;
  assign question_c = qc_q;
  assign alarm_off  = off_q;
  assign wrong      = wrong_q;
  assign remaining  = rem_q;
  assign busy       = busy_q;

endmodule
